alu_arbiter: RTL and testbench

Shares the single combinational 8-bit `alu` between two requesters, such as the core datapath and a secondary engine. Each request carries operands and a 3-bit opcode through a valid/ready handshake. The arbiter grants one requester, drives the ALU from registered operands, and captures the result and zero flag. It then returns them on the winner's response channel. It sits between the requesters and the `alu` instance, and only one operation is in flight at a time.

---
 rtl/alu_pkg.sv | 14 +
 rtl/rr_arb2.sv | 14 +
 rtl/alu_arbiter.sv | 91 +++++++++
 tb/tb_alu_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM encoding and width defaults for the ALU arbiter
package alu_pkg;
  localparam int DATA_W = 8;
  localparam int OP_W = 3;
  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_DEC = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way one-hot arbiter; round-robin with ALU_ARB_RR_EN, fixed priority to requester 0 otherwise
module rr_arb2 (
  input  logic [1:0] valid,
`ifdef ALU_ARB_RR_EN
  input  logic       last,
`endif
  output logic [1:0] grant
);
`ifdef ALU_ARB_RR_EN
  assign grant = &valid ? (last ? 2'b01 : 2'b10) : valid;
`else
  assign grant = valid[0] ? 2'b01 : valid;
`endif
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters, one operation in flight (ALU_ARB_RR_EN selects round-robin)
module alu_arbiter #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W = alu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);
  import alu_pkg::*;
  state_t state, state_nxt;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [OP_W-1:0] op_q;
  logic id_q, zero_q, accept, rsp_fire;
  logic [1:0] grant;
`ifdef ALU_ARB_RR_EN
  logic last_q;
  rr_arb2 u_arb (.valid({req1_valid, req0_valid}), .last(last_q), .grant(grant));
  // last-grant pointer moves on every accept so the loser of a tie wins the next one
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b1;
    else if (accept) last_q <= grant[1];
`else
  rr_arb2 u_arb (.valid({req1_valid, req0_valid}), .grant(grant));
`endif
  assign req0_ready = state == IDLE && grant[0];
  assign req1_ready = state == IDLE && grant[1];
  assign accept = req0_ready || req1_ready;
  assign rsp0_valid = state == RESP && !id_q;
  assign rsp1_valid = state == RESP && id_q;
  assign rsp_fire = id_q ? rsp1_valid && rsp1_ready : rsp0_valid && rsp0_ready;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_zero = zero_q;
  assign rsp1_zero = zero_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_op = op_q;
  assign busy = state != IDLE;
  // next state: accept moves to EXEC, EXEC always lasts one cycle, RESP waits for the handshake
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (accept ? EXEC : IDLE) : state == EXEC ? RESP : (rsp_fire ? IDLE : RESP);
  end
  // state, latched request from the winner, and captured ALU result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      id_q <= 1'b0;
      res_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q <= grant[1] ? req1_a : req0_a;
        b_q <= grant[1] ? req1_b : req0_b;
        op_q <= grant[1] ? req1_op : req0_op;
        id_q <= grant[1];
      end
      if (state == EXEC) begin
        res_q <= alu_result;
        zero_q <= alu_zero;
      end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table, corner sequences and randomized traffic against a behavioural model
module tb_alu_arbiter;
  import alu_pkg::*;
  logic clk = 0, rst = 0;
  logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero, busy, alu_zero;
  logic [7:0] rsp0_result, rsp1_result, alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  int errors = 0, checks = 0, exp_last = 1;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // external ALU the arbiter drives
  always_comb begin
    case (alu_op)
      OP_NOT: alu_result = ~alu_a;
      OP_ADD: alu_result = alu_a + alu_b;
      OP_SUB: alu_result = alu_a - alu_b;
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_XOR: alu_result = alu_a ^ alu_b;
      OP_INC: alu_result = alu_a + 8'd1;
      default: alu_result = alu_a - 8'd1;
    endcase
    alu_zero = alu_result == 8'd0;
  end

  typedef struct {
    int who;
    int a;
    int b;
    logic [2:0] op;
    int res;
    int zero;
  } vec_t;

  function automatic int model_result(int op, int a, int b);
    int r;
    r = op == 0 ? 255 - a : op == 1 ? a + b : op == 2 ? a - b + 256 : op == 3 ? a & b :
        op == 4 ? a | b : op == 5 ? a ^ b : op == 6 ? a + 1 : a + 255;
    return r % 256;
  endfunction

  function automatic int model_winner(bit v0, bit v1);
`ifdef ALU_ARB_RR_EN
    if (v0 && v1) return exp_last == 1 ? 0 : 1;
`endif
    return v0 ? 0 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    exp_last = 1;
  endtask

  task automatic drive(input int who, input int a, input int b, input logic [2:0] op);
    if (who == 0) begin
      req0_valid = 1; req0_a = 8'(a); req0_b = 8'(b); req0_op = op;
    end else begin
      req1_valid = 1; req1_a = 8'(a); req1_b = 8'(b); req1_op = op;
    end
  endtask

  // one uncontended transaction, starting at an IDLE negedge, checking every stage of the timing
  task automatic single(input vec_t v, input string nm);
    rsp0_ready = 1; rsp1_ready = 1;
    drive(v.who, v.a, v.b, v.op);
    #1;
    chk({nm, " ready_T"}, v.who == 0 ? req0_ready : req1_ready, 1);
    chk({nm, " other_ready_T"}, v.who == 0 ? req1_ready : req0_ready, 0);
    exp_last = v.who;
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    chk({nm, " exec_busy"}, busy, 1);
    chk({nm, " exec_no_rsp"}, rsp0_valid | rsp1_valid, 0);
    chk({nm, " exec_alu_a"}, alu_a, v.a);
    chk({nm, " exec_alu_op"}, alu_op, int'(v.op));
    @(negedge clk);
    chk({nm, " rsp_valid"}, v.who == 0 ? rsp0_valid : rsp1_valid, 1);
    chk({nm, " other_rsp"}, v.who == 0 ? rsp1_valid : rsp0_valid, 0);
    chk({nm, " result"}, v.who == 0 ? rsp0_result : rsp1_result, v.res);
    chk({nm, " zero"}, v.who == 0 ? rsp0_zero : rsp1_zero, v.zero);
    @(negedge clk);
    chk({nm, " back_idle"}, busy, 0);
  endtask

  initial begin
    vec_t tab[8];
    int order[4];
    int exp_order[4];
    int got;
    tab[0] = '{0, 20, 15, OP_ADD, 35, 0};
    tab[1] = '{1, 50, 50, OP_SUB, 0, 1};
    tab[2] = '{0, 1, 0, OP_DEC, 0, 1};
    tab[3] = '{1, 255, 1, OP_ADD, 0, 1};
    tab[4] = '{0, 15, 0, OP_NOT, 240, 0};
    tab[5] = '{1, 204, 170, OP_AND, 136, 0};
    tab[6] = '{0, 204, 170, OP_OR, 238, 0};
    tab[7] = '{1, 255, 0, OP_INC, 0, 1};

    @(negedge clk);
    rst = 1;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_ready", {req0_ready, req1_ready}, 0);
    chk("reset_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("reset_results", {rsp0_result, rsp1_result, rsp0_zero, rsp1_zero}, 0);
    chk("reset_alu_drive", {alu_a, alu_b, alu_op}, 0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 8; i++) single(tab[i], $sformatf("vec%0d", i));

    // stalled response: result must hold, other requester locked out
    rsp0_ready = 0;
    drive(0, 204, 170, OP_XOR);
    @(negedge clk);
    req0_valid = 0;
    drive(1, 5, 0, OP_INC);
    #1;
    chk("stall_exec_req1_ready", req1_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("stall_rsp0_valid", rsp0_valid, 1);
      chk("stall_result", rsp0_result, 102);
      chk("stall_req1_ready", req1_ready, 0);
    end
    rsp0_ready = 1;
    @(negedge clk);
    #1;
    chk("stall_release_req1_ready", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    chk("after_stall_rsp1", rsp1_valid, 1);
    chk("after_stall_result", rsp1_result, 6);
    @(negedge clk);

    // reset during EXEC discards the operation
    drive(1, 99, 0, OP_INC);
    #1;
    chk("rstmid_ready", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    rst = 1;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_outputs", {alu_a, alu_b, alu_op, rsp1_result, rsp1_zero, rsp0_result, rsp0_zero}, 0);
    chk("rstmid_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    @(negedge clk);
    rst = 0;
    exp_last = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid_no_rsp", rsp1_valid, 0);
    end
    single('{1, 99, 0, OP_INC, 100, 0}, "rstmid_reissue");

    // both requesters valid every cycle
    do_reset();
`ifdef ALU_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    rsp0_ready = 1; rsp1_ready = 1;
    drive(0, 1, 1, OP_ADD);
    drive(1, 2, 2, OP_ADD);
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        order[got] = req1_ready ? 1 : 0;
        got++;
      end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    chk("tie_count", got, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("tie_grant%0d", i), got > i ? order[i] : 9, exp_order[i]);
    repeat (4) @(negedge clk);

    // randomized traffic with random contention and response stalls
    do_reset();
    for (int n = 0; n < 40; n++) begin
      bit v0, v1;
      int w, a0, b0, a1, b1, stall, exp_res;
      logic [2:0] o0, o1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      a0 = $urandom_range(0, 255); b0 = $urandom_range(0, 255); o0 = 3'($urandom_range(0, 7));
      a1 = $urandom_range(0, 255); b1 = $urandom_range(0, 255); o1 = 3'($urandom_range(0, 7));
      stall = $urandom_range(0, 3);
      w = model_winner(v0, v1);
      exp_res = w == 0 ? model_result(o0, a0, b0) : model_result(o1, a1, b1);
      rsp0_ready = 0; rsp1_ready = 0;
      if (v0) drive(0, a0, b0, o0);
      if (v1) drive(1, a1, b1, o1);
      #1;
      chk("rnd_grant", {req1_ready, req0_ready}, w == 0 ? 1 : 2);
      exp_last = w;
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      for (int s = 0; s < stall; s++) begin
        chk("rnd_stall_valid", w == 0 ? rsp0_valid : rsp1_valid, 1);
        @(negedge clk);
      end
      chk("rnd_rsp_valid", {rsp1_valid, rsp0_valid}, w == 0 ? 1 : 2);
      chk("rnd_result", w == 0 ? rsp0_result : rsp1_result, exp_res);
      chk("rnd_zero", w == 0 ? rsp0_zero : rsp1_zero, exp_res == 0 ? 1 : 0);
      rsp0_ready = 1; rsp1_ready = 1;
      @(negedge clk);
      chk("rnd_idle", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
